// File: rtl/change_dispenser.sv
// Coin-change payout: pulses one ejector solenoid per coin and waits for the chute sensor to confirm it.
// Optional build macro CHG_DISP_RETRY_EN: one retry per coin before a missing confirmation latches a fault.
`timescale 1ns/1ps
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chg_valid,
  input  logic [2:0] chg_beg,
  input  logic       chg_obeg,
  input  logic       sense_beg,
  input  logic       sense_obeg,
  input  logic       fault_clr,
  output logic       eject_beg,
  output logic       eject_obeg,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] remaining
);

  localparam int MAX_A   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               obeg_pend;
  logic               sense_hit;
`ifdef CHG_DISP_RETRY_EN
  logic               retry_used;
`endif

  // True on the last cycle of an n-cycle phase (counter starts at 0 on phase entry)
  function automatic logic cnt_hit(input logic [CNT_W-1:0] c, input int n);
    return c == CNT_W'(n - 1);
  endfunction

  // The 500-unit coin is always paid first, so the pending flag selects the active coin type
  assign sense_hit = obeg_pend ? sense_obeg : sense_beg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      obeg_pend  <= 1'b0;
      eject_beg  <= 1'b0;
      eject_obeg <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      remaining  <= 4'd0;
`ifdef CHG_DISP_RETRY_EN
      retry_used <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (chg_valid) begin
            if (chg_beg == 3'd0 && !chg_obeg) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              obeg_pend  <= chg_obeg;
              remaining  <= {3'b000, chg_obeg} + {1'b0, chg_beg};
              busy       <= 1'b1;
              cnt        <= '0;
              eject_obeg <= chg_obeg;
              eject_beg  <= !chg_obeg;
              state      <= S_PULSE;
`ifdef CHG_DISP_RETRY_EN
              retry_used <= 1'b0;
`endif
            end
          end
        end

        S_PULSE: begin
          if (cnt_hit(cnt, PULSE_CYCLES)) begin
            eject_beg  <= 1'b0;
            eject_obeg <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_WAIT_ACK: begin
          if (sense_hit) begin
            cnt       <= '0;
            obeg_pend <= 1'b0;
            remaining <= remaining - 4'd1;
`ifdef CHG_DISP_RETRY_EN
            retry_used <= 1'b0;
`endif
            if (remaining == 4'd1) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end else if (cnt_hit(cnt, TIMEOUT_CYCLES)) begin
            cnt <= '0;
`ifdef CHG_DISP_RETRY_EN
            if (!retry_used) begin
              retry_used <= 1'b1;
              state      <= S_GAP;
            end else begin
              fault <= 1'b1;
              state <= S_FAULT;
            end
`else
            fault <= 1'b1;
            state <= S_FAULT;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt_hit(cnt, GAP_CYCLES)) begin
            cnt        <= '0;
            eject_obeg <= obeg_pend;
            eject_beg  <= !obeg_pend;
            state      <= S_PULSE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          remaining <= 4'd0;
          state     <= S_IDLE;
        end

        // Untransferred change is dropped on clear; upstream decides whether to re-request
        S_FAULT: begin
          if (fault_clr) begin
            fault     <= 1'b0;
            busy      <= 1'b0;
            remaining <= 4'd0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table of payout requests, a chute-sensor model and a scoreboard monitor.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int TMO   = 16;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset, chg_valid, chg_obeg, sense_beg, sense_obeg, fault_clr;
  logic [2:0] chg_beg;
  logic       eject_beg, eject_obeg, busy, done, fault;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser #(
    .PULSE_CYCLES  (PULSE),
    .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chg_valid (chg_valid),
    .chg_beg   (chg_beg),
    .chg_obeg  (chg_obeg),
    .sense_beg (sense_beg),
    .sense_obeg(sense_obeg),
    .fault_clr (fault_clr),
    .eject_beg (eject_beg),
    .eject_obeg(eject_obeg),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining)
  );

  typedef struct {
    int beg;
    bit obeg;
    int dly;
    int ack_stop;
  } vec_t;

  // Scoreboard: expected ejection types (1 = 500-unit) and expected remaining values in order of change
  bit ej_q[$];
  int rem_q[$];

  // Chute model controls
  bit model_en   = 1'b0;
  int ack_dly    = 3;
  int ack_stop   = 99;
  int pulse_idx  = 0;
  bit force_beg  = 1'b0;
  bit force_obeg = 1'b0;

  // Monitor state
  bit mon_en     = 1'b0;
  bit skip_width = 1'b0;
  int done_cnt   = 0;
  bit busy_seen  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Chute sensor: after ack_dly cycles from the end of an eject pulse, pulse the matching sensor
  initial begin
    bit pb, po, ptype;
    int pend;
    pb = 1'b0; po = 1'b0; ptype = 1'b0; pend = 0;
    sense_beg  = 1'b0;
    sense_obeg = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sense_beg  = force_beg;
      sense_obeg = force_obeg;
      if (!model_en) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (ptype) sense_obeg = 1'b1;
            else       sense_beg  = 1'b1;
          end
        end
        if ((pb && !eject_beg) || (po && !eject_obeg)) begin
          if (pulse_idx < ack_stop) begin
            pend  = ack_dly;
            ptype = po && !eject_obeg;
          end
          pulse_idx++;
        end
      end
      pb = eject_beg;
      po = eject_obeg;
    end
  end

  // Output monitor: pops the scoreboard on every eject rise and remaining change
  initial begin
    bit m_pb, m_po, rise_b, rise_o, gap_armed;
    int m_rem, width, gap_cnt, e;
    m_pb = 1'b0; m_po = 1'b0; gap_armed = 1'b0;
    m_rem = 0; width = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (eject_beg || eject_obeg) check("one_solenoid", int'(eject_beg & eject_obeg), 0);
        if (gap_armed) gap_cnt++;
        rise_b = eject_beg && !m_pb;
        rise_o = eject_obeg && !m_po;
        if (rise_b || rise_o) begin
          if (ej_q.size() == 0) check("eject_unexpected", 1, 0);
          else check("eject_type", int'(rise_o), int'(ej_q.pop_front()));
          if (gap_armed) begin
            check("gap_len", gap_cnt, GAP);
            gap_armed = 1'b0;
          end
          width = 0;
        end
        if (eject_beg || eject_obeg) width++;
        if (((m_pb && !eject_beg) || (m_po && !eject_obeg)) && !skip_width)
          check("pulse_len", width, PULSE);
        if (int'(remaining) != m_rem) begin
          if (rem_q.size() == 0) begin
            check("remaining_unexpected_change", int'(remaining), m_rem);
          end else begin
            e = rem_q.pop_front();
            check("remaining", int'(remaining), e);
            if (int'(remaining) < m_rem && remaining != 4'd0) begin
              gap_armed = 1'b1;
              gap_cnt   = 0;
            end
          end
        end
        if (done) begin
          done_cnt++;
          check("done_busy_low", int'(busy), 0);
          check("done_remaining_zero", int'(remaining), 0);
        end
        busy_seen = busy_seen | busy;
        m_pb  = eject_beg;
        m_po  = eject_obeg;
        m_rem = int'(remaining);
      end
    end
  end

  // First coin index that will not be confirmed in time (n when all confirm)
  function automatic int fail_idx(input vec_t v);
    int n;
    n = v.beg + int'(v.obeg);
    for (int i = 0; i < n; i++)
      if (i >= v.ack_stop || v.dly >= TMO) return i;
    return n;
  endfunction

  task automatic start_vec(input vec_t v, output int n, output int f, output int d0);
    bit t;
    n = v.beg + int'(v.obeg);
    f = fail_idx(v);
    if (n > 0) rem_q.push_back(n);
    for (int i = 0; i < n && i <= f; i++) begin
      t = v.obeg && (i == 0);
      ej_q.push_back(t);
      if (i == f) begin
`ifdef CHG_DISP_RETRY_EN
        ej_q.push_back(t);
`endif
      end else begin
        rem_q.push_back(n - 1 - i);
      end
    end
    if (f < n) rem_q.push_back(0);
    ack_dly   = v.dly;
    ack_stop  = v.ack_stop;
    pulse_idx = 0;
    busy_seen = 1'b0;
    d0        = done_cnt;
    chg_beg   = 3'(v.beg);
    chg_obeg  = v.obeg;
    chg_valid = 1'b1;
    step();
    chg_valid = 1'b0;
    check($sformatf("%s_accept_busy", "req"), int'(busy), int'(n > 0));
  endtask

  task automatic finish_vec(input string tag, input int n, input int f, input int d0);
    int k;
    if (n == 0) check({tag, "_zero_done_next"}, int'(done), 1);
    for (k = 0; k < 400; k++) begin
      if (done || fault) break;
      step();
    end
    check({tag, "_finished_in_budget"}, int'(k < 400), 1);
    check({tag, "_fault"}, int'(fault), int'(f < n));
    if (f < n) begin
      check({tag, "_frozen_remaining"}, int'(remaining), n - f);
      check({tag, "_fault_busy"}, int'(busy), 1);
      chg_beg   = 3'd1;
      chg_obeg  = 1'b0;
      chg_valid = 1'b1;
      step();
      chg_valid = 1'b0;
      check({tag, "_fault_holds"}, int'(fault), 1);
      check({tag, "_fault_no_eject"}, int'(eject_beg | eject_obeg), 0);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      check({tag, "_clr_fault"}, int'(fault), 0);
      check({tag, "_clr_busy"}, int'(busy), 0);
      check({tag, "_clr_remaining"}, int'(remaining), 0);
    end else begin
      step();
      check({tag, "_idle_busy"}, int'(busy), 0);
    end
    repeat (3) step();
    check({tag, "_done_count"}, done_cnt - d0, (f < n) ? 0 : 1);
    check({tag, "_busy_seen"}, int'(busy_seen), int'(n > 0));
    check({tag, "_eject_queue_empty"}, ej_q.size(), 0);
    check({tag, "_remaining_queue_empty"}, rem_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   n, f, d0, k;

    vecs[0] = '{2, 1'b0, 3, 99};   // two 100-unit coins
    vecs[1] = '{1, 1'b1, 3, 99};   // 500-unit first, then 100-unit
    vecs[2] = '{0, 1'b0, 3, 99};   // empty request
    vecs[3] = '{3, 1'b0, 3, 1};    // second coin never confirmed
    vecs[4] = '{7, 1'b1, 1, 99};   // largest request
    vecs[5] = '{1, 1'b0, 15, 99};  // confirmation on the last allowed cycle
    vecs[6] = '{1, 1'b1, 16, 99};  // confirmation one cycle too late
    vecs[7] = '{4, 1'b0, 5, 0};    // first coin never confirmed

    reset     = 1'b1;
    chg_valid = 1'b0;
    chg_beg   = 3'd0;
    chg_obeg  = 1'b0;
    fault_clr = 1'b0;
    repeat (3) step();
    check("reset_eject_beg", int'(eject_beg), 0);
    check("reset_eject_obeg", int'(eject_obeg), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_remaining", int'(remaining), 0);
    reset    = 1'b0;
    model_en = 1'b1;
    mon_en   = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      start_vec(vecs[i], n, f, d0);
      finish_vec($sformatf("vec%0d", i), n, f, d0);
    end

    // New request and stray 500-unit sensor while a 100-unit coin waits for confirmation
    v = '{2, 1'b0, 8, 99};
    start_vec(v, n, f, d0);
    for (k = 0; k < 20; k++) begin
      if (!eject_beg) break;
      step();
    end
    check("ignore_reach_wait", int'(k < 20), 1);
    force_obeg = 1'b1;
    chg_beg    = 3'd7;
    chg_obeg   = 1'b1;
    chg_valid  = 1'b1;
    step();
    force_obeg = 1'b0;
    chg_valid  = 1'b0;
    check("ignore_remaining", int'(remaining), 2);
    check("ignore_busy", int'(busy), 1);
    step();
    check("ignore_remaining_later", int'(remaining), 2);
    check("ignore_no_obeg_eject", int'(eject_obeg), 0);
    finish_vec("ignore", n, f, d0);

    // Reset in the middle of an eject pulse
    v = '{5, 1'b0, 3, 99};
    start_vec(v, n, f, d0);
    step();
    check("abort_pulse_active", int'(eject_beg), 1);
    model_en   = 1'b0;
    skip_width = 1'b1;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    ej_q.delete();
    rem_q.delete();
    rem_q.push_back(0);
    check("abort_eject_beg", int'(eject_beg), 0);
    check("abort_eject_obeg", int'(eject_obeg), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_fault", int'(fault), 0);
    check("abort_remaining", int'(remaining), 0);
    repeat (2) step();
    check("abort_remaining_queue_empty", rem_q.size(), 0);
    skip_width = 1'b0;
    model_en   = 1'b1;
    v = '{2, 1'b1, 2, 99};
    start_vec(v, n, f, d0);
    finish_vec("after_abort", n, f, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
